// File: rtl/fpu_frame_ctrl.sv
// fpu_frame_ctrl
// Byte-stream command framer between a UART byte interface and the FPU datapath.
// Inbound frame : {opcode, A bytes, B bytes}; operand byte order set by RX_LSB_FIRST.
// Outbound frame: {status, result bytes MS byte first}; result omitted on any error.
// Status byte   : [7]=1 marker, [6]=OVR, [5:4]=op_sel, [3]=ERR_OPTO, [2]=ERR_RXTO,
//                 [1]=ERR_OP, [0]=NaN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for an opcode byte
// RX_A      | collecting operand A bytes
// RX_B      | collecting operand B bytes
// EXEC      | op_en asserted for exactly one cycle
// WAIT_RES  | waiting for fpu_ready, optional timeout
// TX_STATUS | presenting the status byte until accepted
// TX_RES    | presenting result bytes, MS byte first
module fpu_frame_ctrl #(
    parameter int DATA_W       = 32,
    parameter bit RX_LSB_FIRST = 1'b1,
    parameter int RX_TIMEOUT   = 0,
    parameter int OP_TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [1:0]        op_sel,
    output logic              op_en,
    input  logic [DATA_W-1:0] fpu_result,
    input  logic              fpu_ready,
    input  logic              fpu_nan,
    output logic              busy
);

    localparam int               NBYTES   = DATA_W / 8;
    localparam int               CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
    localparam bit               RX_TO_EN = (RX_TIMEOUT > 0);
    localparam bit               OP_TO_EN = (OP_TIMEOUT > 0);
    // Timer is loaded with N-1 so the timeout fires on the N-th idle cycle.
    localparam logic [15:0]      RX_LOAD  = RX_TO_EN ? 16'(RX_TIMEOUT - 1) : 16'd0;
    localparam logic [15:0]      OP_LOAD  = OP_TO_EN ? 16'(OP_TIMEOUT - 1) : 16'd0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_A      = 3'd1,
        RX_B      = 3'd2,
        EXEC      = 3'd3,
        WAIT_RES  = 3'd4,
        TX_STATUS = 3'd5,
        TX_RES    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_byte_idx;
    logic [15:0]       r_tmr;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_result;
    logic [1:0]        r_op_sel;
    logic              r_nan;
    logic              r_ovr;
    logic              r_err_op;
    logic              r_err_rxto;
    logic              r_err_opto;
    logic [7:0]        r_status;

    logic [1:0]        w_op_sel_nx;
    logic              w_nan_nx;
    logic              w_ovr_nx;
    logic              w_err_op_nx;
    logic              w_err_rxto_nx;
    logic              w_err_opto_nx;
    logic [7:0]        w_status_nx;

    logic              w_in_rx;
    logic              w_last;
    logic              w_bad_op;
    logic              w_rx_to;
    logic              w_op_to;
    logic              w_tx_fire;
    logic              w_drop;
    logic              w_rx_take;

    assign w_in_rx    = (r_state == RX_A) || (r_state == RX_B);
    assign w_rx_take  = w_in_rx && rx_valid;
    assign w_last     = (r_cnt == LAST_IDX);
    assign w_bad_op   = |rx_data[7:2];
    assign w_rx_to    = RX_TO_EN && w_in_rx && !rx_valid && (r_tmr == 16'd0);
    assign w_op_to    = OP_TO_EN && (r_state == WAIT_RES) && !fpu_ready && (r_tmr == 16'd0);
    assign w_tx_fire  = tx_valid && tx_ready;
    assign w_drop     = rx_valid && (r_state inside {EXEC, WAIT_RES, TX_STATUS, TX_RES});
    assign w_byte_idx = RX_LSB_FIRST ? r_cnt : (LAST_IDX - r_cnt);

    assign op_a   = r_op_a;
    assign op_b   = r_op_b;
    assign op_sel = r_op_sel;
    assign busy   = (r_state != IDLE);

    // State register; reset aborts any frame in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode and the state-derived outputs (op_en, tx_valid, tx_data).
    always_comb begin
        w_state_nx = r_state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        op_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    w_state_nx = w_bad_op ? TX_STATUS : RX_A;
                end
            end
            RX_A: begin
                if (rx_valid && w_last) begin
                    w_state_nx = RX_B;
                end else if (w_rx_to) begin
                    w_state_nx = TX_STATUS;
                end
            end
            RX_B: begin
                if (rx_valid && w_last) begin
                    w_state_nx = EXEC;
                end else if (w_rx_to) begin
                    w_state_nx = TX_STATUS;
                end
            end
            EXEC: begin
                op_en      = 1'b1;
                w_state_nx = WAIT_RES;
            end
            WAIT_RES: begin
                if (fpu_ready || w_op_to) begin
                    w_state_nx = TX_STATUS;
                end
            end
            TX_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = r_status;
                if (tx_ready) begin
                    w_state_nx = (|r_status[3:1]) ? IDLE : TX_RES;
                end
            end
            TX_RES: begin
                tx_valid = 1'b1;
                tx_data  = r_result[DATA_W-1 -: 8];
                if (tx_ready && w_last) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Next values of op_sel and the status flags, so the status snapshot includes
    // any flag raised in the same cycle the FSM heads for TX_STATUS.
    always_comb begin
        w_op_sel_nx   = r_op_sel;
        w_nan_nx      = r_nan;
        w_ovr_nx      = r_ovr;
        w_err_op_nx   = r_err_op;
        w_err_rxto_nx = r_err_rxto;
        w_err_opto_nx = r_err_opto;
        if ((r_state == IDLE) && rx_valid) begin
            w_nan_nx      = 1'b0;
            w_ovr_nx      = 1'b0;
            w_err_rxto_nx = 1'b0;
            w_err_opto_nx = 1'b0;
            w_err_op_nx   = w_bad_op;
            if (!w_bad_op) begin
                w_op_sel_nx = rx_data[1:0];
            end
        end
        if (w_drop) begin
            w_ovr_nx = 1'b1;
        end
        if (w_rx_to) begin
            w_err_rxto_nx = 1'b1;
        end
        if ((r_state == WAIT_RES) && fpu_ready) begin
            w_nan_nx = fpu_nan;
        end
        if (w_op_to) begin
            w_err_opto_nx = 1'b1;
        end
    end

    assign w_status_nx = {1'b1, w_ovr_nx, w_op_sel_nx, w_err_opto_nx,
                          w_err_rxto_nx, w_err_op_nx, w_nan_nx};

    // Datapath: flags, status snapshot, byte counter, operands, result shifter, timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_sel   <= 2'b00;
            r_nan      <= 1'b0;
            r_ovr      <= 1'b0;
            r_err_op   <= 1'b0;
            r_err_rxto <= 1'b0;
            r_err_opto <= 1'b0;
            r_status   <= 8'h00;
            r_cnt      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_result   <= '0;
            r_tmr      <= 16'd0;
        end else begin
            r_op_sel   <= w_op_sel_nx;
            r_nan      <= w_nan_nx;
            r_ovr      <= w_ovr_nx;
            r_err_op   <= w_err_op_nx;
            r_err_rxto <= w_err_rxto_nx;
            r_err_opto <= w_err_opto_nx;

            // Frozen while presented so tx_data cannot move under a stalled handshake.
            if ((w_state_nx == TX_STATUS) && (r_state != TX_STATUS)) begin
                r_status <= w_status_nx;
            end

            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (w_rx_take || ((r_state == TX_RES) && w_tx_fire)) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end

            if (w_rx_take) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (w_byte_idx == CNT_W'(i)) begin
                        if (r_state == RX_A) begin
                            r_op_a[8*i +: 8] <= rx_data;
                        end else begin
                            r_op_b[8*i +: 8] <= rx_data;
                        end
                    end
                end
            end

            if ((r_state == WAIT_RES) && fpu_ready) begin
                r_result <= fpu_result;
            end else if ((r_state == TX_RES) && w_tx_fire) begin
                r_result <= r_result << 8;
            end

            if (((r_state == IDLE) && rx_valid) || w_rx_take) begin
                r_tmr <= RX_LOAD;
            end else if (r_state == EXEC) begin
                r_tmr <= OP_LOAD;
            end else if ((w_in_rx || (r_state == WAIT_RES)) && (r_tmr != 16'd0)) begin
                r_tmr <= r_tmr - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_frame_ctrl.sv
// Testbench for fpu_frame_ctrl: a 32-bit LSB-first instance with both timeouts
// enabled, and a 64-bit MSB-first instance for byte order and mid-TX reset.
module tb_fpu_frame_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        rx_valid, tx_ready, tx_valid, op_en, fpu_ready, fpu_nan, busy;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] op_a, op_b, fpu_result;
    logic [1:0]  op_sel;

    logic        rx_valid_w, tx_ready_w, tx_valid_w, op_en_w, fpu_ready_w, fpu_nan_w, busy_w;
    logic [7:0]  rx_data_w, tx_data_w;
    logic [63:0] op_a_w, op_b_w, fpu_result_w;
    logic [1:0]  op_sel_w;

    fpu_frame_ctrl #(
        .DATA_W(32), .RX_LSB_FIRST(1'b1), .RX_TIMEOUT(100), .OP_TIMEOUT(50)
    ) dut32 (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .op_en(op_en),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready), .fpu_nan(fpu_nan),
        .busy(busy)
    );

    fpu_frame_ctrl #(
        .DATA_W(64), .RX_LSB_FIRST(1'b0), .RX_TIMEOUT(0), .OP_TIMEOUT(0)
    ) dut64 (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid_w), .rx_data(rx_data_w),
        .tx_ready(tx_ready_w), .tx_valid(tx_valid_w), .tx_data(tx_data_w),
        .op_a(op_a_w), .op_b(op_b_w), .op_sel(op_sel_w), .op_en(op_en_w),
        .fpu_result(fpu_result_w), .fpu_ready(fpu_ready_w), .fpu_nan(fpu_nan_w),
        .busy(busy_w)
    );

    typedef struct {
        logic [7:0]  opcode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nan;
        int          delay;
        logic [7:0]  status;
    } vec_t;

    vec_t       vecs[5];
    int         n_pass  = 0;
    int         n_total = 0;
    int         en_cnt  = 0;
    int         e0;
    int         cyc;
    int         budget;
    logic [7:0] txq[$];

    always @(negedge clk) begin
        if (op_en === 1'b1) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_byte_w(input logic [7:0] b);
        rx_data_w  = b;
        rx_valid_w = 1'b1;
        @(negedge clk);
        rx_valid_w = 1'b0;
        rx_data_w  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b);
        send_byte(opc);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    endtask

    task automatic wait_op_en(input string name);
        int bud = 20;
        while (op_en !== 1'b1 && bud > 0) begin
            @(negedge clk);
            bud--;
        end
        check({name, "_op_en_seen"}, {63'd0, op_en}, 64'd1);
    endtask

    task automatic pulse_fpu(input int delay, input logic [31:0] res, input logic nan);
        repeat (delay) @(negedge clk);
        fpu_result = res;
        fpu_nan    = nan;
        fpu_ready  = 1'b1;
        @(negedge clk);
        fpu_ready  = 1'b0;
        fpu_nan    = 1'b0;
        fpu_result = 32'h0;
    endtask

    // Drains the outbound frame until busy drops; optionally stalls tx_ready for
    // 10 cycles once stall_at bytes have been taken.
    task automatic collect_tx(input int stall_at, input string name);
        int         bud = 400;
        bit         stable;
        logic [7:0] held;
        txq.delete();
        while (busy === 1'b1 && bud > 0) begin
            if (tx_valid === 1'b1 && txq.size() == stall_at) begin
                tx_ready = 1'b0;
                held     = tx_data;
                stable   = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (tx_valid !== 1'b1 || tx_data !== held) stable = 1'b0;
                end
                check({name, "_stall_hold"}, {63'd0, stable}, 64'd1);
                tx_ready = 1'b1;
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx_data);
            @(negedge clk);
            bud--;
        end
        check({name, "_idle_after_tx"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_frame(input string name, input logic [7:0] st,
                               input logic [31:0] res, input bit has_res);
        check({name, "_nbytes"}, txq.size(), has_res ? 64'd5 : 64'd1);
        if (txq.size() >= 1) check({name, "_status"}, txq[0], st);
        if (has_res && txq.size() == 5)
            check({name, "_result"}, {txq[1], txq[2], txq[3], txq[4]}, res);
    endtask

    initial begin
        vecs[0] = '{8'h00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 5, 8'h80};
        vecs[1] = '{8'h01, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1, 8'h90};
        vecs[2] = '{8'h02, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 3, 8'hA0};
        vecs[3] = '{8'h03, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0, 2, 8'hB0};
        vecs[4] = '{8'h00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 4, 8'h81};

        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        fpu_ready = 1'b0; fpu_nan = 1'b0; fpu_result = 32'h0;
        rx_valid_w = 1'b0; rx_data_w = 8'h00; tx_ready_w = 1'b1;
        fpu_ready_w = 1'b0; fpu_nan_w = 1'b0; fpu_result_w = 64'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check("rst_op_a", {32'd0, op_a}, 64'd0);
        check("rst_op_b", {32'd0, op_b}, 64'd0);
        check("rst_op_sel", {62'd0, op_sel}, 64'd0);
        check("rst_op_en", {63'd0, op_en}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Illegal opcode: single status byte, no FPU start.
        e0 = en_cnt;
        send_byte(8'h05);
        collect_tx(-1, "badop");
        check_frame("badop", 8'h82, 32'h0, 1'b0);
        check("badop_op_en_count", en_cnt - e0, 64'd0);

        // Overrun byte during WAIT_RES plus NaN result.
        e0 = en_cnt;
        send_frame(8'h02, 32'h40000000, 32'h00000000);
        wait_op_en("ovr");
        @(negedge clk);
        send_byte(8'hAA);
        pulse_fpu(1, 32'h7FC00000, 1'b1);
        collect_tx(-1, "ovr");
        check_frame("ovr", 8'hE1, 32'h7FC00000, 1'b1);
        check("ovr_op_en_count", en_cnt - e0, 64'd1);

        // Table of normal frames, back to back; vector 2 stalls mid-result.
        for (int v = 0; v < 5; v++) begin
            string nm;
            nm = $sformatf("v%0d", v);
            e0 = en_cnt;
            send_frame(vecs[v].opcode, vecs[v].a, vecs[v].b);
            wait_op_en(nm);
            check({nm, "_op_a"}, {32'd0, op_a}, {32'd0, vecs[v].a});
            check({nm, "_op_b"}, {32'd0, op_b}, {32'd0, vecs[v].b});
            check({nm, "_op_sel"}, {62'd0, op_sel}, {62'd0, vecs[v].opcode[1:0]});
            pulse_fpu(vecs[v].delay, vecs[v].res, vecs[v].nan);
            collect_tx((v == 2) ? 3 : -1, nm);
            check_frame(nm, vecs[v].status, vecs[v].res, 1'b1);
            check({nm, "_op_en_count"}, en_cnt - e0, 64'd1);
        end

        // fpu_ready during EXEC must be ignored; the WAIT_RES value is captured.
        send_frame(8'h03, 32'h40000000, 32'h3F800000);
        wait_op_en("exec_ign");
        fpu_result = 32'hDEADBEEF;
        fpu_ready  = 1'b1;
        @(negedge clk);
        fpu_result = 32'h3F800000;
        @(negedge clk);
        fpu_ready  = 1'b0;
        fpu_result = 32'h0;
        collect_tx(-1, "exec_ign");
        check_frame("exec_ign", 8'hB0, 32'h3F800000, 1'b1);

        // FPU never answers: op timeout after 50 waiting cycles.
        send_frame(8'h00, 32'h00000001, 32'h00000002);
        wait_op_en("opto");
        cyc = 0;
        while (tx_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("opto_cycles", cyc, 64'd51);
        collect_tx(-1, "opto");
        check_frame("opto", 8'h88, 32'h0, 1'b0);

        // Truncated frame: RX timeout after 100 idle cycles.
        e0 = en_cnt;
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        cyc = 0;
        while (tx_valid !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("rxto_cycles", cyc, 64'd100);
        collect_tx(-1, "rxto");
        check_frame("rxto", 8'h94, 32'h0, 1'b0);
        check("rxto_op_en_count", en_cnt - e0, 64'd0);

        // 64-bit MSB-first instance: operand assembly, then reset during TX_RES.
        send_byte_w(8'h00);
        for (int i = 1; i <= 8; i++) send_byte_w(8'(i));
        for (int i = 1; i <= 8; i++) send_byte_w(8'(8'h10 + i));
        budget = 20;
        while (op_en_w !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("w64_op_en_seen", {63'd0, op_en_w}, 64'd1);
        check("w64_op_a", op_a_w, 64'h0102030405060708);
        check("w64_op_b", op_b_w, 64'h1112131415161718);
        repeat (2) @(negedge clk);
        fpu_result_w = 64'hA1A2A3A4A5A6A7A8;
        fpu_ready_w  = 1'b1;
        @(negedge clk);
        fpu_ready_w  = 1'b0;
        fpu_result_w = 64'h0;
        txq.delete();
        budget = 50;
        while (txq.size() < 3 && budget > 0) begin
            if (tx_valid_w === 1'b1 && tx_ready_w === 1'b1) txq.push_back(tx_data_w);
            @(negedge clk);
            budget--;
        end
        check("w64_nbytes_before_reset", txq.size(), 64'd3);
        if (txq.size() == 3) check("w64_head", {40'd0, txq[0], txq[1], txq[2]}, 64'h80A1A2);
        check("w64_tx_res_data", {56'd0, tx_data_w}, 64'hA3);
        reset = 1'b1;
        #1;
        check("w64_rst_tx_valid", {63'd0, tx_valid_w}, 64'd0);
        check("w64_rst_tx_data", {56'd0, tx_data_w}, 64'd0);
        check("w64_rst_op_a", op_a_w, 64'd0);
        check("w64_rst_op_b", op_b_w, 64'd0);
        check("w64_rst_op_sel", {62'd0, op_sel_w}, 64'd0);
        check("w64_rst_op_en", {63'd0, op_en_w}, 64'd0);
        check("w64_rst_busy", {63'd0, busy_w}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
